// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Brief    : Multi-cycle restoring divider, signed/unsigned, one quotient bit
//            per clock, with start/busy/done handshake and error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W  = $clog2(WIDTH);
    localparam logic [1:0]       S_IDLE = 2'd0;
    localparam logic [1:0]       S_CALC = 2'd1;
    localparam logic [1:0]       S_FIX  = 2'd2;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_done;
    logic             r_dbz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_sgn;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic             w_dvs_zero;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;

    generate
        if (SIGNED_EN) begin : g_signed
            assign w_sgn     = signed_mode;
            assign w_dvd_mag = (signed_mode && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
            assign w_dvs_mag = (signed_mode && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
        end else begin : g_unsigned
            logic w_unused_signed_mode;
            assign w_unused_signed_mode = signed_mode;
            assign w_sgn     = 1'b0;
            assign w_dvd_mag = dividend;
            assign w_dvs_mag = divisor;
        end
    endgenerate

    assign w_dvs_zero = (divisor == '0);

    // The partial remainder is always below the divisor, so only the shifted
    // value needs the extra top bit; the stored remainder fits in WIDTH bits.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[WIDTH-1:0] - r_dvs;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_dvs_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        if (r_state != S_IDLE) begin
            busy = 1'b1;
        end
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_dbz <= w_dvs_zero;
                        r_ovf <= w_sgn && (dividend == C_MIN) && (divisor == '1);
                        r_dvs <= w_dvs_mag;
                        if (w_dvs_zero) begin
                            // Divide-by-zero result is raw and never sign-corrected
                            r_quo   <= '1;
                            r_rem   <= dividend;
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                        end else begin
                            r_quo   <= w_dvd_mag;
                            r_rem   <= '0;
                            r_q_neg <= w_sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                            r_r_neg <= w_sgn && dividend[WIDTH-1];
                        end
                    end
                end
                S_CALC: begin
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quotient  <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                    r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
                    r_done      <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Directed self-checking bench for seq_divider at WIDTH 16, 8, 32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;

    logic        start, signed_mode;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        busy, done, dbz, ovf;

    logic        start_8, signed_mode_8;
    logic [7:0]  dividend_8, divisor_8, quotient_8, remainder_8;
    logic        busy_8, done_8, dbz_8, ovf_8;

    logic        start_32, signed_mode_32;
    logic [31:0] dividend_32, divisor_32, quotient_32, remainder_32;
    logic        busy_32, done_32, dbz_32, ovf_32;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(dbz), .overflow(ovf)
    );

    seq_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start_8), .signed_mode(signed_mode_8),
        .dividend(dividend_8), .divisor(divisor_8), .busy(busy_8), .done(done_8),
        .quotient(quotient_8), .remainder(remainder_8),
        .div_by_zero(dbz_8), .overflow(ovf_8)
    );

    seq_divider #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk(clk), .rst(rst), .start(start_32), .signed_mode(signed_mode_32),
        .dividend(dividend_32), .divisor(divisor_32), .busy(busy_32), .done(done_32),
        .quotient(quotient_32), .remainder(remainder_32),
        .div_by_zero(dbz_32), .overflow(ovf_32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; the start pulse spans exactly one cycle, then the
    // operand inputs are scrambled to show they are not re-sampled.
    task automatic start16(input logic sm, input logic [15:0] a, input logic [15:0] b);
        start       = 1'b1;
        signed_mode = sm;
        dividend    = a;
        divisor     = b;
        @(negedge clk);
        start       = 1'b0;
        signed_mode = ~sm;
        dividend    = 16'($urandom);
        divisor     = 16'($urandom);
    endtask

    // Entered at the negedge of cycle lat0 after the start cycle; returns at
    // the negedge of the done cycle.
    task automatic wait16(input string tag, input int lat0,
                          input logic [15:0] exp_q, input logic [15:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf, input int exp_lat);
        int lat = lat0;
        int bc  = lat0 - 1;
        while (!done && lat < 200) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(bc), 64'(exp_lat - 1));
        chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
        chk({tag, "_q"},    64'(quotient), 64'(exp_q));
        chk({tag, "_r"},    64'(remainder), 64'(exp_r));
        chk({tag, "_dbz"},  64'(dbz), 64'(exp_dbz));
        chk({tag, "_ovf"},  64'(ovf), 64'(exp_ovf));
    endtask

    initial begin
        int lat;
        int dcount;

        rst = 1'b1;
        start = 1'b0;    signed_mode = 1'b0;    dividend = '0;    divisor = '0;
        start_8 = 1'b0;  signed_mode_8 = 1'b0;  dividend_8 = '0;  divisor_8 = '0;
        start_32 = 1'b0; signed_mode_32 = 1'b0; dividend_32 = '0; divisor_32 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_q",    64'(quotient), 64'(0));
        chk("rst_r",    64'(remainder), 64'(0));
        chk("rst_ctrl", 64'({busy, done, dbz, ovf}), 64'(0));

        start16(1'b0, 16'd100, 16'd7);
        wait16("u100_7", 1, 16'd14, 16'd2, 1'b0, 1'b0, 18);

        start16(1'b1, 16'hFF9C, 16'd7);
        wait16("sneg_pos", 1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18);
        start16(1'b1, 16'd100, 16'hFFF9);
        wait16("spos_neg", 1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18);
        start16(1'b1, 16'hFF9C, 16'hFFF9);
        wait16("sneg_neg", 1, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 18);

        start16(1'b1, 16'h8000, 16'hFFFF);
        wait16("s_ovf", 1, 16'h8000, 16'h0000, 1'b0, 1'b1, 18);
        start16(1'b0, 16'h8000, 16'hFFFF);
        wait16("u_noovf", 1, 16'h0000, 16'h8000, 1'b0, 1'b0, 18);

        start16(1'b0, 16'h1234, 16'h0000);
        wait16("dbz", 1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 2);
        start16(1'b0, 16'd100, 16'd7);
        chk("dbz_cleared", 64'(dbz), 64'(0));
        wait16("after_dbz", 1, 16'd14, 16'd2, 1'b0, 1'b0, 18);

        // start during a busy division must be ignored
        start16(1'b0, 16'd1000, 16'd10);
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 16'd50; divisor = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait16("ignore_busy", 6, 16'd100, 16'd0, 1'b0, 1'b0, 18);
        start16(1'b0, 16'd50, 16'd3);
        wait16("b2b", 1, 16'd16, 16'd2, 1'b0, 1'b0, 18);

        // reset during iteration 8 aborts the division
        start16(1'b1, 16'h8000, 16'hFFFF);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_q",    64'(quotient), 64'(0));
        chk("abort_r",    64'(remainder), 64'(0));
        chk("abort_ctrl", 64'({busy, done, dbz, ovf}), 64'(0));
        dcount = 0;
        repeat (30) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(dcount), 64'(0));

        start_8 = 1'b1; dividend_8 = 8'hFF; divisor_8 = 8'h01; signed_mode_8 = 1'b0;
        @(negedge clk);
        start_8 = 1'b0; dividend_8 = 8'h00;
        lat = 1;
        while (!done_8 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("w8_lat",  64'(lat), 64'(10));
        chk("w8_q",    64'(quotient_8), 64'(8'hFF));
        chk("w8_r",    64'(remainder_8), 64'(0));
        chk("w8_ctrl", 64'({busy_8, dbz_8, ovf_8}), 64'(0));

        start_32 = 1'b1; dividend_32 = 32'hFFFF_FFFF; divisor_32 = 32'h1; signed_mode_32 = 1'b0;
        @(negedge clk);
        start_32 = 1'b0; dividend_32 = '0;
        lat = 1;
        while (!done_32 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("w32_lat",  64'(lat), 64'(34));
        chk("w32_q",    64'(quotient_32), 64'(32'hFFFF_FFFF));
        chk("w32_r",    64'(remainder_32), 64'(0));
        chk("w32_ctrl", 64'({busy_32, dbz_32, ovf_32}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
